// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the unified memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_BYTE = 4'b0001;

  // Streak counter width; comfortably holds any sensible starvation limit.
  localparam int STREAK_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selection, LS priority with IF starvation guard
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic                if_req,
  input  logic                ls_req,
  input  logic [STREAK_W-1:0] streak,
  input  logic [STREAK_W-1:0] limit,
  output logic                grant_if,
  output logic                grant_ls
);

  // IF wins only when LS has starved it for the full limit; otherwise LS first.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (if_req && ls_req && (streak == limit)) begin
      grant_if = 1'b1;
    end else if (ls_req) begin
      grant_ls = 1'b1;
    end else if (if_req) begin
      grant_if = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [3:0]  i_ls_mask,
  input  logic        i_ls_unsigned,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  output logic        o_ls_ready,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_mask,
  output logic        o_mem_unsigned,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam logic [3:0]          CNT_INIT = 4'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] LIMIT    = STREAK_W'(STARVE_LIMIT);

  arb_state_t          state;
  arb_owner_t          owner;
  logic [3:0]          cnt;
  logic                was_store;
  logic [STREAK_W-1:0] streak;

  logic resp_cycle;
  logic grant_window;
  logic grant_if;
  logic grant_ls;

  assign resp_cycle   = (state == ST_BUSY) && (cnt == 4'd0) && !i_rst;
  assign grant_window = !i_rst && ((state == ST_IDLE) || resp_cycle);

  mem_arb_pick u_pick (
    .if_req   (i_if_req && grant_window),
    .ls_req   (i_ls_req && grant_window),
    .streak   (streak),
    .limit    (LIMIT),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // Memory command, handshakes and response routing; everything is zero while in reset.
  always_comb begin
    o_mem_req      = grant_if || grant_ls;
    o_mem_we       = 1'b0;
    o_mem_mask     = 4'b0000;
    o_mem_unsigned = 1'b0;
    o_mem_addr     = 32'd0;
    o_mem_wdata    = 32'd0;
    o_if_ready     = grant_if;
    o_ls_ready     = grant_ls;
    o_if_rvalid    = 1'b0;
    o_if_rdata     = 32'd0;
    o_ls_rvalid    = 1'b0;
    o_ls_rdata     = 32'd0;
    o_busy         = (state == ST_BUSY) && !i_rst;
    if (grant_ls) begin
      o_mem_we       = i_ls_we;
      o_mem_mask     = i_ls_mask;
      o_mem_unsigned = i_ls_unsigned;
      o_mem_addr     = i_ls_addr;
      o_mem_wdata    = i_ls_wdata;
    end else if (grant_if) begin
      o_mem_mask = MASK_WORD;
      o_mem_addr = i_if_addr;
    end
    if (resp_cycle) begin
      if (owner == OWN_LS) begin
        o_ls_rvalid = 1'b1;
        o_ls_rdata  = was_store ? 32'd0 : i_mem_rdata;
      end else begin
        o_if_rvalid = 1'b1;
        o_if_rdata  = i_mem_rdata;
      end
    end
  end

  // Transaction tracking: issue, latency countdown, response/back-to-back, starvation streak.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      cnt       <= 4'd0;
      was_store <= 1'b0;
      streak    <= '0;
    end else if (grant_if || grant_ls) begin
      state     <= ST_BUSY;
      owner     <= grant_ls ? OWN_LS : OWN_IF;
      cnt       <= CNT_INIT;
      was_store <= grant_ls && i_ls_we;
      if (grant_ls && i_if_req) begin
        streak <= (streak == LIMIT) ? streak : streak + 1'b1;
      end else begin
        streak <= '0;
      end
    end else if (resp_cycle) begin
      state <= ST_IDLE;
    end else if ((state == ST_BUSY) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - checks latency-2 and latency-1 arbiters against a timeline model
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_mask;
  logic        ls_uns;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] mem_rdata;

  logic [1:0]  if_ready, if_rvalid, ls_ready, ls_rvalid;
  logic [1:0]  mem_req, mem_we, mem_uns, busy;
  logic [31:0] if_rdata [2];
  logic [31:0] ls_rdata [2];
  logic [3:0]  mem_mask [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(LIMIT)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ready(if_ready[0]), .o_if_rvalid(if_rvalid[0]), .o_if_rdata(if_rdata[0]),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_mask(ls_mask), .i_ls_unsigned(ls_uns),
    .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_ready(ls_ready[0]), .o_ls_rvalid(ls_rvalid[0]), .o_ls_rdata(ls_rdata[0]),
    .o_mem_req(mem_req[0]), .o_mem_we(mem_we[0]), .o_mem_mask(mem_mask[0]),
    .o_mem_unsigned(mem_uns[0]), .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]),
    .i_mem_rdata(mem_rdata), .o_busy(busy[0])
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ready(if_ready[1]), .o_if_rvalid(if_rvalid[1]), .o_if_rdata(if_rdata[1]),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_mask(ls_mask), .i_ls_unsigned(ls_uns),
    .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_ready(ls_ready[1]), .o_ls_rvalid(ls_rvalid[1]), .o_ls_rdata(ls_rdata[1]),
    .o_mem_req(mem_req[1]), .o_mem_we(mem_we[1]), .o_mem_mask(mem_mask[1]),
    .o_mem_unsigned(mem_uns[1]), .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]),
    .i_mem_rdata(mem_rdata), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a transaction issued at cycle c answers at cycle c+latency,
  // and the port is free again for a new issue in that answer cycle.
  int lat [2] = '{2, 1};
  int cyc = 0;
  bit m_act [2];
  int m_resp_at [2];
  bit m_is_ls [2];
  bit m_is_store [2];
  int m_streak [2];

  always @(negedge clk) begin
    bit resp, gi, gl;
    logic [31:0] rd;
    for (int k = 0; k < 2; k++) begin
      resp = 1'b0; gi = 1'b0; gl = 1'b0;
      if (!rst) begin
        resp = m_act[k] && (cyc == m_resp_at[k]);
        if (!m_act[k] || resp) begin
          if (if_req && ls_req && m_streak[k] == LIMIT) gi = 1'b1;
          else if (ls_req) gl = 1'b1;
          else if (if_req) gi = 1'b1;
        end
      end
      rd = (resp && !m_is_store[k]) ? mem_rdata : 32'd0;
      chk($sformatf("dut%0d mem_req", k), 32'(mem_req[k]), 32'(gi | gl));
      chk($sformatf("dut%0d mem_we", k), 32'(mem_we[k]), 32'(gl & ls_we));
      chk($sformatf("dut%0d mem_mask", k), 32'(mem_mask[k]),
          gl ? 32'(ls_mask) : (gi ? 32'hF : 32'd0));
      chk($sformatf("dut%0d mem_uns", k), 32'(mem_uns[k]), 32'(gl & ls_uns));
      chk($sformatf("dut%0d mem_addr", k), mem_addr[k], gl ? ls_addr : (gi ? if_addr : 32'd0));
      chk($sformatf("dut%0d mem_wdata", k), mem_wdata[k], gl ? ls_wdata : 32'd0);
      chk($sformatf("dut%0d if_ready", k), 32'(if_ready[k]), 32'(gi));
      chk($sformatf("dut%0d ls_ready", k), 32'(ls_ready[k]), 32'(gl));
      chk($sformatf("dut%0d if_rvalid", k), 32'(if_rvalid[k]), 32'(resp && !m_is_ls[k]));
      chk($sformatf("dut%0d ls_rvalid", k), 32'(ls_rvalid[k]), 32'(resp && m_is_ls[k]));
      chk($sformatf("dut%0d if_rdata", k), if_rdata[k], (resp && !m_is_ls[k]) ? rd : 32'd0);
      chk($sformatf("dut%0d ls_rdata", k), ls_rdata[k], (resp && m_is_ls[k]) ? rd : 32'd0);
      chk($sformatf("dut%0d busy", k), 32'(busy[k]), 32'(m_act[k] && !rst));
      if (rst) begin
        m_act[k] = 1'b0;
        m_streak[k] = 0;
      end else if (gi || gl) begin
        m_act[k] = 1'b1;
        m_resp_at[k] = cyc + lat[k];
        m_is_ls[k] = gl;
        m_is_store[k] = gl && ls_we;
        if (gl && if_req) m_streak[k] = (m_streak[k] < LIMIT) ? m_streak[k] + 1 : LIMIT;
        else m_streak[k] = 0;
      end else if (resp) begin
        m_act[k] = 1'b0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h4; ls_req = 1'b0; ls_we = 1'b0;
    ls_mask = 4'hF; ls_uns = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; mem_rdata = 32'd0;
    repeat (3) tick();
    peek();
    chk("reset if_ready", 32'(if_ready[0]), 32'd0);
    chk("reset mem_req", 32'(mem_req[0]), 32'd0);
    chk("reset busy", 32'(busy[0]), 32'd0);
    tick();
    rst = 1'b0;
    idle(2);

    // single fetch
    if_req = 1'b1; if_addr = 32'h10;
    peek();
    chk("fetch c0 if_ready", 32'(if_ready[0]), 32'd1);
    chk("fetch c0 mem_req", 32'(mem_req[0]), 32'd1);
    chk("fetch c0 mem_mask", 32'(mem_mask[0]), 32'hF);
    chk("fetch c0 mem_addr", mem_addr[0], 32'h10);
    tick(); if_req = 1'b0;
    peek();
    chk("fetch c1 busy", 32'(busy[0]), 32'd1);
    chk("fetch c1 mem_req", 32'(mem_req[0]), 32'd0);
    tick(); mem_rdata = 32'hDEADBEEF;
    peek();
    chk("fetch c2 if_rvalid", 32'(if_rvalid[0]), 32'd1);
    chk("fetch c2 if_rdata", if_rdata[0], 32'hDEADBEEF);
    tick();
    idle(3);

    // store
    ls_req = 1'b1; ls_we = 1'b1; ls_mask = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'h1234;
    peek();
    chk("store c0 ls_ready", 32'(ls_ready[0]), 32'd1);
    chk("store c0 mem_we", 32'(mem_we[0]), 32'd1);
    chk("store c0 mem_mask", 32'(mem_mask[0]), 32'h3);
    chk("store c0 mem_wdata", mem_wdata[0], 32'h1234);
    tick(); ls_req = 1'b0;
    tick(); mem_rdata = 32'hCAFEF00D;
    peek();
    chk("store c2 ls_rvalid", 32'(ls_rvalid[0]), 32'd1);
    chk("store c2 ls_rdata", ls_rdata[0], 32'd0);
    tick();
    idle(3);

    // collision: LS first, IF back-to-back in the response cycle
    ls_mask = 4'hF;
    if_req = 1'b1; if_addr = 32'h20; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
    peek();
    chk("coll c0 ls_ready", 32'(ls_ready[0]), 32'd1);
    chk("coll c0 if_ready", 32'(if_ready[0]), 32'd0);
    tick(); ls_req = 1'b0;
    peek();
    chk("coll c1 if_ready", 32'(if_ready[0]), 32'd0);
    tick(); mem_rdata = 32'h11112222;
    peek();
    chk("coll c2 ls_rvalid", 32'(ls_rvalid[0]), 32'd1);
    chk("coll c2 ls_rdata", ls_rdata[0], 32'h11112222);
    chk("coll c2 if_ready", 32'(if_ready[0]), 32'd1);
    tick(); if_req = 1'b0;
    tick(); mem_rdata = 32'h33334444;
    peek();
    chk("coll c4 if_rvalid", 32'(if_rvalid[0]), 32'd1);
    chk("coll c4 if_rdata", if_rdata[0], 32'h33334444);
    tick();
    idle(3);

    // starvation guard
    if_req = 1'b1; if_addr = 32'h24; ls_req = 1'b1; ls_addr = 32'h84;
    for (int c = 0; c <= 10; c++) begin
      peek();
      chk($sformatf("starve c%0d ls_ready", c), 32'(ls_ready[0]), 32'((c % 2 == 0) && (c != 8)));
      chk($sformatf("starve c%0d if_ready", c), 32'(if_ready[0]), 32'(c == 8));
      tick();
    end
    idle(3);

    // reset mid-transaction
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h90;
    peek();
    chk("rstmid c0 ls_ready", 32'(ls_ready[0]), 32'd1);
    tick(); rst = 1'b1; ls_req = 1'b0;
    peek();
    chk("rstmid c1 busy", 32'(busy[0]), 32'd0);
    chk("rstmid c1 ls_rvalid", 32'(ls_rvalid[0]), 32'd0);
    tick();
    peek();
    chk("rstmid c2 ls_rvalid", 32'(ls_rvalid[0]), 32'd0);
    tick(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h30;
    peek();
    chk("rstmid first if_ready", 32'(if_ready[0]), 32'd1);
    tick();
    idle(4);

    // latency-1 instance, continuous fetch
    if_req = 1'b1; if_addr = 32'h50;
    for (int c = 0; c <= 4; c++) begin
      if (c == 3) if_req = 1'b0;
      peek();
      chk($sformatf("lat1 c%0d if_ready", c), 32'(if_ready[1]), 32'(c < 3));
      chk($sformatf("lat1 c%0d if_rvalid", c), 32'(if_rvalid[1]), 32'(c >= 1 && c <= 3));
      chk($sformatf("lat1 c%0d busy", c), 32'(busy[1]), 32'(c >= 1 && c <= 3));
      tick();
    end
    idle(3);

    // mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      if_req    = ($urandom_range(0, 2) != 0);
      ls_req    = ($urandom_range(0, 2) != 0);
      ls_we     = $urandom_range(0, 1) == 1;
      ls_uns    = $urandom_range(0, 1) == 1;
      ls_mask   = 4'($urandom);
      if_addr   = $urandom;
      ls_addr   = $urandom;
      ls_wdata  = $urandom;
      mem_rdata = $urandom;
      tick();
    end
    rst = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
